maq_bcd_cnt: RTL and testbench

Parametrised two-digit BCD time counter stage, the generalised successor of the fixed seconds counter. One instance covers seconds or minutes (0..59), 24 h hours (0..23) or 12 h hours (1..12) through parameters. Adds up/down counting, synchronous preset load with range checking, and single-cycle carry/borrow pulses for chaining. Instances cascade by wiring carry (or borrow) of one stage to enable of the next. All stages run on the 50 MHz system clock, and the 1 Hz tick arrives as an enable.

---
 rtl/maq_bcd_cnt.sv | 112 +++++++++++
 tb/tb_maq_bcd_cnt.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/maq_bcd_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : maq_bcd_cnt
//  Purpose  : Parametrised two-digit BCD up/down counter stage with preset
//             load, range-checked loads and chainable carry/borrow pulses.
//  Revision : 1.0  initial release
// ============================================================================
module maq_bcd_cnt #(
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 59,
    parameter int MSD_W   = 3
) (
    input  logic             maqb_clock,
    input  logic             maqb_reset,
    input  logic             maqb_enable,
    input  logic             maqb_down,
    input  logic             maqb_load,
    input  logic [3:0]       maqb_load_lsd,
    input  logic [MSD_W-1:0] maqb_load_msd,
    output logic [3:0]       maqb_lsd,
    output logic [MSD_W-1:0] maqb_msd,
    output logic             maqb_carry,
    output logic             maqb_borrow,
    output logic             maqb_load_err
);

    // Wide enough for (2**MSD_W - 1) * 10 + 15, the largest preset pair.
    localparam int               c_vw      = MSD_W + 4;
    localparam logic [3:0]       c_min_lsd = 4'(MIN_VAL % 10);
    localparam logic [MSD_W-1:0] c_min_msd = MSD_W'(MIN_VAL / 10);
    localparam logic [3:0]       c_max_lsd = 4'(MAX_VAL % 10);
    localparam logic [MSD_W-1:0] c_max_msd = MSD_W'(MAX_VAL / 10);

    if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL <= 99 &&
          (MAX_VAL / 10) < (1 << MSD_W))) begin : g_param_check
        $error("maq_bcd_cnt: illegal MIN_VAL/MAX_VAL/MSD_W combination");
    end

    logic [3:0]       r_lsd;
    logic [MSD_W-1:0] r_msd;
    logic             r_carry;
    logic             r_borrow;
    logic             r_load_err;

    logic             w_at_max;
    logic             w_at_min;
    logic [c_vw-1:0]  w_load_val;
    logic             w_load_ok;

    assign w_at_max   = (r_lsd == c_max_lsd) && (r_msd == c_max_msd);
    assign w_at_min   = (r_lsd == c_min_lsd) && (r_msd == c_min_msd);
    // Range check only; the count itself never leaves the digit domain.
    assign w_load_val = {4'b0000, maqb_load_msd} * c_vw'(10) +
                        {{MSD_W{1'b0}}, maqb_load_lsd};
    assign w_load_ok  = (maqb_load_lsd <= 4'd9) &&
                        (int'(w_load_val) >= MIN_VAL) &&
                        (int'(w_load_val) <= MAX_VAL);

    always_ff @(posedge maqb_clock) begin
        if (maqb_reset) begin
            r_lsd      <= c_min_lsd;
            r_msd      <= c_min_msd;
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_load_err <= 1'b0;
            if (maqb_load) begin
                if (w_load_ok) begin
                    r_lsd <= maqb_load_lsd;
                    r_msd <= maqb_load_msd;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (maqb_enable) begin
                if (!maqb_down) begin
                    if (w_at_max) begin
                        r_lsd   <= c_min_lsd;
                        r_msd   <= c_min_msd;
                        r_carry <= 1'b1;
                    end else if (r_lsd == 4'd9) begin
                        r_lsd <= 4'd0;
                        r_msd <= r_msd + MSD_W'(1);
                    end else begin
                        r_lsd <= r_lsd + 4'd1;
                    end
                end else begin
                    if (w_at_min) begin
                        r_lsd    <= c_max_lsd;
                        r_msd    <= c_max_msd;
                        r_borrow <= 1'b1;
                    end else if (r_lsd == 4'd0) begin
                        r_lsd <= 4'd9;
                        r_msd <= r_msd - MSD_W'(1);
                    end else begin
                        r_lsd <= r_lsd - 4'd1;
                    end
                end
            end
        end
    end

    assign maqb_lsd      = r_lsd;
    assign maqb_msd      = r_msd;
    assign maqb_carry    = r_carry;
    assign maqb_borrow   = r_borrow;
    assign maqb_load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_maq_bcd_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_maq_bcd_cnt
//  Purpose  : Bench for three maq_bcd_cnt flavours (00..59, 01..12, 00..23)
//             driven in parallel and compared to a decimal reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_maq_bcd_cnt;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       dn  = 1'b0;
    logic       ld  = 1'b0;
    logic [3:0] ll  = 4'd0;
    logic [2:0] lm  = 3'd0;

    logic [3:0] lsd0, lsd1, lsd2;
    logic [2:0] msd0;
    logic [0:0] msd1;
    logic [1:0] msd2;
    logic       c0, c1, c2, b0, b1, b2, e0, e1, e2;

    always #10 clk = ~clk;

    maq_bcd_cnt #(.MIN_VAL(0), .MAX_VAL(59), .MSD_W(3)) dut0 (
        .maqb_clock(clk), .maqb_reset(rst), .maqb_enable(en), .maqb_down(dn),
        .maqb_load(ld), .maqb_load_lsd(ll), .maqb_load_msd(lm),
        .maqb_lsd(lsd0), .maqb_msd(msd0), .maqb_carry(c0), .maqb_borrow(b0),
        .maqb_load_err(e0));

    maq_bcd_cnt #(.MIN_VAL(1), .MAX_VAL(12), .MSD_W(1)) dut1 (
        .maqb_clock(clk), .maqb_reset(rst), .maqb_enable(en), .maqb_down(dn),
        .maqb_load(ld), .maqb_load_lsd(ll), .maqb_load_msd(lm[0:0]),
        .maqb_lsd(lsd1), .maqb_msd(msd1), .maqb_carry(c1), .maqb_borrow(b1),
        .maqb_load_err(e1));

    maq_bcd_cnt #(.MIN_VAL(0), .MAX_VAL(23), .MSD_W(2)) dut2 (
        .maqb_clock(clk), .maqb_reset(rst), .maqb_enable(en), .maqb_down(dn),
        .maqb_load(ld), .maqb_load_lsd(ll), .maqb_load_msd(lm[1:0]),
        .maqb_lsd(lsd2), .maqb_msd(msd2), .maqb_carry(c2), .maqb_borrow(b2),
        .maqb_load_err(e2));

    int errors = 0;
    int checks = 0;

    // Decimal reference model: value, pulses and wrap/pulse tallies per instance.
    int vmin[3] = '{0, 1, 0};
    int vmax[3] = '{59, 12, 23};
    int vw[3]   = '{3, 1, 2};
    int mv[3], mc[3], mb[3], me[3];
    int wrap_c[3], wrap_b[3], seen_c[3], seen_b[3];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int k, input bit r, input bit e, input bit d,
                              input bit l, input int lsd_in, input int msd_in);
        int lv;
        mc[k] = 0; mb[k] = 0; me[k] = 0;
        if (r) begin
            mv[k] = vmin[k];
        end else if (l) begin
            lv = (msd_in % (1 << vw[k])) * 10 + lsd_in;
            if (lsd_in <= 9 && lv >= vmin[k] && lv <= vmax[k]) mv[k] = lv;
            else me[k] = 1;
        end else if (e) begin
            if (!d) begin
                if (mv[k] == vmax[k]) begin mv[k] = vmin[k]; mc[k] = 1; end
                else mv[k] = mv[k] + 1;
            end else begin
                if (mv[k] == vmin[k]) begin mv[k] = vmax[k]; mb[k] = 1; end
                else mv[k] = mv[k] - 1;
            end
        end
        wrap_c[k] += mc[k];
        wrap_b[k] += mb[k];
    endtask

    task automatic check_inst(input int k, input int l, input int m,
                              input int c, input int b, input int e);
        chk($sformatf("i%0d_lsd", k), l, mv[k] % 10);
        chk($sformatf("i%0d_msd", k), m, mv[k] / 10);
        chk($sformatf("i%0d_carry", k), c, mc[k]);
        chk($sformatf("i%0d_borrow", k), b, mb[k]);
        chk($sformatf("i%0d_load_err", k), e, me[k]);
        chk($sformatf("i%0d_in_range", k),
            int'(l <= 9 && (m * 10 + l) >= vmin[k] && (m * 10 + l) <= vmax[k]), 1);
        seen_c[k] += c;
        seen_b[k] += b;
    endtask

    task automatic cyc(input bit r, input bit e, input bit d, input bit l,
                       input logic [3:0] lsd_in, input logic [2:0] msd_in);
        rst = r; en = e; dn = d; ld = l; ll = lsd_in; lm = msd_in;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, r, e, d, l, int'(lsd_in), int'(msd_in));
        #1;
        check_inst(0, int'(lsd0), int'(msd0), int'(c0), int'(b0), int'(e0));
        check_inst(1, int'(lsd1), int'(msd1), int'(c1), int'(b1), int'(e1));
        check_inst(2, int'(lsd2), int'(msd2), int'(c2), int'(b2), int'(e2));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 4'd0, 3'd0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            mv[k] = vmin[k]; wrap_c[k] = 0; wrap_b[k] = 0; seen_c[k] = 0; seen_b[k] = 0;
        end

        cyc(1, 0, 0, 0, 4'd0, 3'd0);
        chk("reset_lsd0", int'(lsd0), 0);
        chk("reset_msd0", int'(msd0), 0);
        chk("reset_lsd1", int'(lsd1), 1);

        // Full minute sweep, one tick every four clocks.
        for (int i = 0; i < 60; i++) begin
            cyc(0, 1, 0, 0, 4'd0, 3'd0);
            if (i == 59) chk("sweep_wrap_carry", int'(c0), 1);
            idle(3);
        end
        chk("sweep_end_value", int'(msd0) * 10 + int'(lsd0), 0);
        chk("sweep_carries", seen_c[0], 1);
        chk("sweep_borrows", seen_b[0], 0);

        // Rejected loads.
        cyc(0, 0, 0, 1, 4'd0, 3'd6);
        chk("load60_err", int'(e0), 1);
        idle(1);
        chk("load_err_one_cycle", int'(e0), 0);
        cyc(0, 0, 0, 1, 4'hA, 3'd1);
        chk("loadA_err", int'(e0), 1);

        // Load wins over a simultaneous enable.
        cyc(0, 1, 0, 1, 4'd5, 3'd4);
        chk("load45_msd", int'(msd0), 4);
        chk("load45_lsd", int'(lsd0), 5);

        // Enable held across the 59 -> 00 wrap.
        cyc(0, 0, 0, 1, 4'd9, 3'd5);
        cyc(0, 1, 0, 0, 4'd0, 3'd0);
        chk("hold_wrap_v0", int'(msd0) * 10 + int'(lsd0), 0);
        chk("hold_wrap_c0", int'(c0), 1);
        cyc(0, 1, 0, 0, 4'd0, 3'd0);
        chk("hold_wrap_v1", int'(msd0) * 10 + int'(lsd0), 1);
        chk("hold_wrap_c1", int'(c0), 0);
        cyc(0, 1, 0, 0, 4'd0, 3'd0);
        chk("hold_wrap_v2", int'(msd0) * 10 + int'(lsd0), 2);

        // Reset dominates enable mid-count.
        cyc(0, 0, 0, 1, 4'd7, 3'd3);
        cyc(1, 1, 0, 0, 4'd0, 3'd0);
        chk("rst37_value", int'(msd0) * 10 + int'(lsd0), 0);
        chk("rst37_carry", int'(c0), 0);

        // 24 h stage: digit-pair carry and borrow across 19/20.
        cyc(0, 0, 0, 1, 4'd9, 3'd1);
        cyc(0, 1, 0, 0, 4'd0, 3'd0);
        chk("h24_up_20", int'(msd2) * 10 + int'(lsd2), 20);
        cyc(0, 1, 1, 0, 4'd0, 3'd0);
        chk("h24_down_19", int'(msd2) * 10 + int'(lsd2), 19);
        chk("h24_no_borrow", int'(b2), 0);

        // 12 h stage: full cycle then borrow from 01.
        cyc(1, 0, 0, 0, 4'd0, 3'd0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 4'd0, 3'd0);
        chk("h12_wrap_01", int'(msd1) * 10 + int'(lsd1), 1);
        chk("h12_carry", int'(c1), 1);
        cyc(0, 1, 1, 0, 4'd0, 3'd0);
        chk("h12_down_12", int'(msd1) * 10 + int'(lsd1), 12);
        chk("h12_borrow", int'(b1), 1);

        // Randomised traffic.
        for (int i = 0; i < 10000; i++) begin
            automatic bit         r  = ($urandom_range(0, 255) == 0);
            automatic bit         l  = ($urandom_range(0, 7) == 0);
            automatic bit         e  = $urandom_range(0, 1) == 1;
            automatic bit         d  = $urandom_range(0, 1) == 1;
            automatic logic [3:0] rl = ($urandom_range(0, 3) == 0) ?
                                       4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            automatic logic [2:0] rm = 3'($urandom_range(0, 7));
            cyc(r, e, d, l, rl, rm);
        end
        idle(2);

        for (int k = 0; k < 3; k++) begin
            chk($sformatf("i%0d_carry_count", k), seen_c[k], wrap_c[k]);
            chk($sformatf("i%0d_borrow_count", k), seen_b[k], wrap_b[k]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
